shdw_to_mb: RTL and testbench

//  Command/data bridge between a MicroBlaze FSL pair and the SPARC shadow/error-injection logic.

---
 rtl/shdw_to_mb.sv | 182 ++++++++++++++++++
 tb/tb_shdw_to_mb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shdw_to_mb.sv
// shdw_to_mb: bridges a MicroBlaze FSL pair to the SPARC shadow/error-injection
// logic. Decodes command words from the FSL slave, drives injection/reset/enable
// controls, and streams shadow dump data plus trailer/status words out through a
// small FIFO onto the FSL master.
module shdw_to_mb #(
  parameter int NCH      = 32,
  parameter int FIFO_DEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [31:0]     fsl_m_data,
  output logic            fsl_m_ctrl,
  output logic            fsl_m_write,
  input  logic            fsl_m_full,
  output logic            fsl_s_read,
  input  logic [31:0]     fsl_s_data,
  input  logic            fsl_s_ctrl,
  input  logic            fsl_s_exists,
  output logic            err_en,
  output logic [11:0]     err_ctrl,
  output logic            sh_rst,
  output logic            c_en,
  output logic [NCH-1:0]  dump_en,
  input  logic [31:0]     sh_out,
  input  logic [NCH-1:0]  sh_out_vld,
  input  logic [NCH-1:0]  sh_out_done
);
  localparam int AW = $clog2(FIFO_DEP);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DUMP, S_TRAIL} state_t;

  state_t          r_state;
  logic [4:0]      r_ch;
  logic [15:0]     r_cnt;
  logic            r_err_en;
  logic [11:0]     r_err_ctrl;
  logic            r_sh_rst;
  logic            r_c_en;
  logic [NCH-1:0]  r_dump_en;

  // FIFO storage: bit 32 is the FSL control bit, [31:0] the data word
  logic [32:0]     r_mem [FIFO_DEP];
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_fcnt;

  logic [3:0]      w_op;
  logic            w_empty, w_full, w_pop, w_push;
  logic            w_ch_bad, w_blk, w_read, w_dec;
  logic            w_vld, w_done, w_room2;
  logic [32:0]     w_pdat, w_head;
  logic [15:0]     w_cnt_inc;
  logic [CW-1:0]   w_fcnt_nxt;
  logic [NCH-1:0]  w_one, w_oh_cmd, w_oh_ch;
  logic            w_unused_ok;

  assign w_op       = fsl_s_data[31:28];
  assign w_empty    = (r_fcnt == '0);
  assign w_full     = (r_fcnt == CW'(FIFO_DEP));
  assign w_pop      = rst & ~w_empty & ~fsl_m_full;
  assign w_ch_bad   = ({27'b0, fsl_s_data[4:0]} >= 32'(NCH));
  // commands that push in their decode cycle must not be consumed while full
  assign w_blk      = w_full & ((w_op == 4'h5) | ((w_op == 4'h4) & w_ch_bad));
  assign w_read     = rst & (r_state == S_IDLE) & fsl_s_exists & ~(~fsl_s_ctrl & w_blk);
  assign w_dec      = w_read & ~fsl_s_ctrl;
  assign w_vld      = sh_out_vld[r_ch];
  assign w_done     = sh_out_done[r_ch];
  assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_fcnt_nxt = r_fcnt + CW'(w_push) - CW'(w_pop);
  // dump_en only stays up while two entries would remain free, so a word
  // arriving one cycle after the drop still has a slot
  assign w_room2    = (w_fcnt_nxt <= CW'(FIFO_DEP - 2));
  assign w_one      = {{(NCH-1){1'b0}}, 1'b1};
  assign w_oh_cmd   = w_one << fsl_s_data[4:0];
  assign w_oh_ch    = w_one << r_ch;
  assign w_head     = r_mem[r_rp];
  assign w_unused_ok = ^fsl_s_data[27:12];

  assign fsl_m_data  = w_empty ? 32'h0 : w_head[31:0];
  assign fsl_m_ctrl  = ~w_empty & w_head[32];
  assign fsl_m_write = w_pop;
  assign fsl_s_read  = w_read;
  assign err_en      = r_err_en;
  assign err_ctrl    = r_err_ctrl;
  assign sh_rst      = r_sh_rst;
  assign c_en        = r_c_en;
  assign dump_en     = r_dump_en;

  // select what (if anything) enters the FIFO this cycle
  always_comb begin
    w_push = 1'b0;
    w_pdat = '0;
    case (r_state)
      S_IDLE: begin
        if (w_dec && w_op == 4'h5) begin
          w_push = 1'b1;
          w_pdat = {1'b1, 4'h5, 14'b0, w_full, r_c_en, r_err_ctrl};
        end else if (w_dec && w_op == 4'h4 && w_ch_bad) begin
          w_push = 1'b1;
          w_pdat = {1'b1, 4'hD, 7'b0, fsl_s_data[4:0], 16'h0};
        end
      end
      S_DUMP: begin
        w_push = w_vld;
        w_pdat = {1'b0, sh_out};
      end
      S_TRAIL: begin
        w_push = ~w_full;
        w_pdat = {1'b1, 4'hD, 7'b0, r_ch, r_cnt};
      end
      default: ;
    endcase
  end

  // FIFO data array, no reset needed: occupancy gates the outputs
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_pdat;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_fcnt <= w_fcnt_nxt;
    end
  end

  // command decode / dump sequencing with registered control outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_cnt      <= '0;
      r_err_en   <= 1'b0;
      r_err_ctrl <= '0;
      r_sh_rst   <= 1'b0;
      r_c_en     <= 1'b0;
      r_dump_en  <= '0;
    end else begin
      r_err_en  <= 1'b0;
      r_sh_rst  <= 1'b0;
      r_dump_en <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_dec) begin
            case (w_op)
              4'h1: begin
                r_err_ctrl <= fsl_s_data[11:0];
                r_err_en   <= 1'b1;
              end
              4'h2: r_sh_rst <= 1'b1;
              4'h3: r_c_en   <= fsl_s_data[0];
              4'h4: begin
                if (!w_ch_bad) begin
                  r_ch      <= fsl_s_data[4:0];
                  r_cnt     <= '0;
                  r_state   <= S_DUMP;
                  r_dump_en <= w_room2 ? w_oh_cmd : '0;
                end
              end
              default: ;
            endcase
          end
        end
        S_DUMP: begin
          if (w_vld) r_cnt <= w_cnt_inc;
          if (w_done) r_state   <= S_TRAIL;
          else        r_dump_en <= w_room2 ? w_oh_ch : '0;
        end
        S_TRAIL: begin
          if (!w_full) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shdw_to_mb.sv
// tb_shdw_to_mb: randomized bench with a queue-based reference model of the
// FSL output stream and the control outputs, plus directed literal checks.
module tb_shdw_to_mb;
  localparam int NCH = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     fsl_m_data;
  logic            fsl_m_ctrl, fsl_m_write;
  logic            fsl_m_full = 1'b0;
  logic            fsl_s_read;
  logic [31:0]     fsl_s_data = '0;
  logic            fsl_s_ctrl = 1'b0;
  logic            fsl_s_exists = 1'b0;
  logic            err_en;
  logic [11:0]     err_ctrl;
  logic            sh_rst, c_en;
  logic [NCH-1:0]  dump_en;
  logic [31:0]     sh_out = '0;
  logic [NCH-1:0]  sh_out_vld = '0;
  logic [NCH-1:0]  sh_out_done = '0;

  shdw_to_mb #(.NCH(NCH), .FIFO_DEP(4)) dut (
    .clk(clk), .rst(rst),
    .fsl_m_data(fsl_m_data), .fsl_m_ctrl(fsl_m_ctrl), .fsl_m_write(fsl_m_write),
    .fsl_m_full(fsl_m_full), .fsl_s_read(fsl_s_read), .fsl_s_data(fsl_s_data),
    .fsl_s_ctrl(fsl_s_ctrl), .fsl_s_exists(fsl_s_exists),
    .err_en(err_en), .err_ctrl(err_ctrl), .sh_rst(sh_rst), .c_en(c_en),
    .dump_en(dump_en), .sh_out(sh_out), .sh_out_vld(sh_out_vld),
    .sh_out_done(sh_out_done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  logic [32:0] exp_q[$];
  logic [32:0] rx_q[$];
  logic [31:0] sh_q[$];
  logic        m_err_en = 0, m_sh_rst = 0, m_c_en = 0;
  logic [11:0] m_err_ctrl = '0;
  bit          m_dumping = 0, m_dump_end = 0;
  int          m_dch = 0, m_dcnt = 0;
  int          sh_delay = 0;
  bit          noise6 = 0, full_force = 0, full_rand = 0, prev_den = 0;
  logic        sh_allowed;
  int          oc, rop, nw;
  logic [31:0] rd;
  logic [32:0] ev;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rx4(input string nm, input logic [32:0] a, input logic [32:0] b,
                         input logic [32:0] c, input logic [32:0] d);
    logic [32:0] lit [4];
    lit = '{a, b, c, d};
    chk({nm, "_count"}, rx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) chk({nm, "_word"}, rx_q[i], lit[i]);
  endtask

  // per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_err_en = 0; m_sh_rst = 0; m_c_en = 0; m_err_ctrl = '0;
      m_dumping = 0; m_dump_end = 0;
    end else begin
      chk("err_en", err_en, m_err_en);
      chk("err_ctrl", err_ctrl, m_err_ctrl);
      chk("sh_rst", sh_rst, m_sh_rst);
      chk("c_en", c_en, m_c_en);
      chk("read_no_word", fsl_s_read & ~fsl_s_exists, 0);
      if (m_dumping && !m_dump_end) chk("read_in_dump", fsl_s_read, 0);
      if (m_dumping) chk("dump_en_sel", (dump_en == '0) || (dump_en == (32'h1 << m_dch)), 1);
      else           chk("dump_en_idle", dump_en, 0);
      if (fsl_m_write) begin
        chk("write_full", fsl_m_full, 0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_word: got 0x%0h expected none", {fsl_m_ctrl, fsl_m_data});
        end else begin
          ev = exp_q.pop_front();
          chk("m_word", {fsl_m_ctrl, fsl_m_data}, ev);
        end
        rx_q.push_back({fsl_m_ctrl, fsl_m_data});
      end
      if (m_dump_end) begin m_dumping = 0; m_dump_end = 0; end
      if (m_dumping && !m_dump_end) begin
        if (sh_out_vld[m_dch]) begin
          exp_q.push_back({1'b0, sh_out});
          if (m_dcnt < 16'hFFFF) m_dcnt++;
        end
        if (sh_out_done[m_dch]) begin
          exp_q.push_back({1'b1, 4'hD, 7'b0, 5'(m_dch), 16'(m_dcnt)});
          m_dump_end = 1;
        end
      end
      m_err_en = 0; m_sh_rst = 0;
      if (fsl_s_read && !fsl_s_ctrl) begin
        case (fsl_s_data[31:28])
          4'h1: begin m_err_ctrl = fsl_s_data[11:0]; m_err_en = 1; end
          4'h2: m_sh_rst = 1;
          4'h3: m_c_en = fsl_s_data[0];
          4'h4: begin m_dumping = 1; m_dump_end = 0; m_dch = int'(fsl_s_data[4:0]); m_dcnt = 0; end
          4'h5: exp_q.push_back({1'b1, 4'h5, 14'b0, 1'b0, m_c_en, m_err_ctrl});
          default: ;
        endcase
      end
    end
  end

  // shadow-logic model: words only while dump_en[ch] is up or just dropped
  initial forever begin
    @(posedge clk); #1;
    sh_out_vld = '0; sh_out_done = '0; sh_out = $urandom;
    if (rst && m_dumping && !m_dump_end) begin
      sh_allowed = dump_en[m_dch] | prev_den;
      if (sh_q.size() > 0) begin
        if (sh_allowed && $urandom_range(0, 3) != 0) begin
          sh_out = sh_q.pop_front();
          sh_out_vld[m_dch] = 1'b1;
          if (sh_q.size() == 0) sh_out_done[m_dch] = 1'b1;
        end
      end else if (sh_delay > 0) sh_delay--;
      else sh_out_done[m_dch] = 1'b1;
      if (noise6 || $urandom_range(0, 2) == 0) begin
        oc = noise6 ? 6 : (m_dch + 1 + int'($urandom_range(0, 30))) % NCH;
        sh_out_vld[oc] = 1'b1;
        if ($urandom_range(0, 3) == 0) sh_out_done[oc] = 1'b1;
      end
    end
    prev_den = (rst && m_dumping) ? dump_en[m_dch] : 1'b0;
  end

  // FSL master backpressure
  initial forever begin
    @(posedge clk); #1;
    fsl_m_full = full_force | (full_rand & ($urandom_range(0, 2) == 0));
  end

  task automatic send_cmd(input logic [31:0] d, input logic c);
    bit got = 0;
    @(posedge clk); #1;
    fsl_s_data = d; fsl_s_ctrl = c; fsl_s_exists = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (fsl_s_read) got = 1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_read: got no fsl_s_read expected one for 0x%0h", d);
    end
    @(posedge clk); #1;
    fsl_s_exists = 1'b0; fsl_s_ctrl = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!m_dumping && exp_q.size() == 0) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got %0d pending words expected 0", exp_q.size());
    end
  endtask

  initial begin
    // reset with a pending command word
    fsl_s_exists = 1'b1; fsl_s_data = 32'h1000_0ABC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {fsl_s_read, fsl_m_write, fsl_m_ctrl, err_en, sh_rst, c_en, err_ctrl}, 0);
    chk("rst_data", {fsl_m_data, dump_en}, 0);
    @(posedge clk); #1;
    fsl_s_exists = 1'b0; rst = 1'b1;

    // ERR
    send_cmd(32'h1000_0ABC, 1'b0);
    @(negedge clk);
    chk("t2_err_en", err_en, 1);
    chk("t2_err_ctrl", err_ctrl, 12'hABC);
    @(negedge clk);
    chk("t2_err_en_off", err_en, 0);
    chk("t2_err_hold", err_ctrl, 12'hABC);

    // CEN then STAT
    rx_q.delete();
    send_cmd(32'h3000_0001, 1'b0);
    send_cmd(32'h5000_0000, 1'b0);
    wait_idle();
    chk("t3_c_en", c_en, 1);
    chk("t3_stat_n", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t3_stat", rx_q[$], {1'b1, 32'h5000_1ABC});

    // DUMP ch3
    rx_q.delete();
    sh_q = '{32'h11, 32'h22, 32'h33}; sh_delay = 0;
    send_cmd(32'h4000_0003, 1'b0);
    @(negedge clk);
    chk("t4_dump_en", dump_en, 32'h8);
    wait_idle();
    chk_rx4("t4", {1'b0, 32'h11}, {1'b0, 32'h22}, {1'b0, 32'h33}, {1'b1, 32'hD003_0003});

    // same dump under 20 cycles of backpressure
    rx_q.delete();
    sh_q = '{32'h11, 32'h22, 32'h33}; sh_delay = 0;
    full_force = 1;
    send_cmd(32'h4000_0003, 1'b0);
    repeat (20) @(posedge clk);
    #1 full_force = 0;
    chk("t5_held", rx_q.size(), 0);
    wait_idle();
    chk_rx4("t5", {1'b0, 32'h11}, {1'b0, 32'h22}, {1'b0, 32'h33}, {1'b1, 32'hD003_0003});

    // DUMP ch5 with traffic only on ch6
    rx_q.delete();
    sh_q.delete(); sh_delay = 6; noise6 = 1;
    send_cmd(32'h4000_0005, 1'b0);
    wait_idle();
    noise6 = 0;
    chk("t6_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t6_trailer", rx_q[0], {1'b1, 32'hD005_0000});

    // reset in the middle of a stalled dump
    for (int i = 0; i < 8; i++) sh_q.push_back($urandom);
    sh_delay = 0; full_force = 1;
    send_cmd(32'h4000_0007, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0; full_force = 0; sh_q.delete();
    @(posedge clk); @(negedge clk);
    chk("mr_dump_en", dump_en, 0);
    chk("mr_ctl", {fsl_m_write, c_en, err_en, err_ctrl}, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mr_flushed", {fsl_m_write, fsl_m_ctrl, fsl_m_data}, 0);

    // randomized command stream
    full_rand = 1;
    for (int k = 0; k < 250; k++) begin
      rop = $urandom_range(0, 7);
      if (rop == 7) rop = $urandom_range(6, 15);
      rd = {4'(rop), 28'($urandom)};
      if (rop == 4) begin
        wait_idle();
        sh_q.delete();
        nw = $urandom_range(0, 8);
        for (int j = 0; j < nw; j++) sh_q.push_back($urandom);
        sh_delay = $urandom_range(0, 4);
      end
      send_cmd(rd, $urandom_range(0, 7) == 0);
    end
    full_rand = 0;
    wait_idle();
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
